led_share_arbiter: RTL

- Round-robin arbiter/scheduler that shares the 4-bit board LED bank between four pattern requesters.
- Each winner's 4-bit pattern is shown for a fixed dwell time, followed by a blank gap, before the next arbitration.
- Sits between the LED pattern FSMs (sources) and the LED pins. It replaces direct per-source drive of led_out.

---
 rtl/led_share_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/led_share_arbiter.sv
// led_share_arbiter
// Round-robin scheduler that shares the 4-bit LED bank between four pattern
// sources. The winner's pattern is latched and shown for DWELL cycles, or
// until the winner drops its request. A blank gap of GAP cycles follows,
// then one idle arbitration cycle before the next grant.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   req      - level request per source, held until served
//   pat_in   - four 4-bit patterns, source i at [4i+3:4i]
//   grant    - registered one-hot owner, zero when nobody owns the LEDs
//   led_out  - registered LED drive
//   done     - one-cycle one-hot pulse after a source completes a full dwell
//   busy     - high while showing or in the blank gap
module led_share_arbiter #(
  parameter int unsigned DWELL = 67108864,
  parameter int unsigned GAP   = 4,
  parameter int unsigned CNT_W = 26
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [15:0] pat_in,
  output logic [3:0]  grant,
  output logic [3:0]  led_out,
  output logic [3:0]  done,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Terminal counts, truncated to the counter width.
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [1:0]       last_r, last_s;
  logic [1:0]       owner_r, owner_s;
  logic [3:0]       pat_r, pat_s;
  logic [3:0]       grant_s, led_s, done_s;
  logic             busy_s;
  logic [1:0]       win_s;

  // First set request bit searching last+1, last+2, ... (mod 4).
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = last + 2'd1;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  // Winner of the current arbitration round.
  always_comb begin
    win_s = pick_winner(req, last_r);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    last_s  = last_r;
    owner_s = owner_r;
    pat_s   = pat_r;
    grant_s = grant;
    led_s   = led_out;
    done_s  = 4'b0000;
    busy_s  = busy;
    case (state_r)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          grant_s = 4'b0001 << win_s;
          led_s   = pat_in[{win_s, 2'b00} +: 4];
          pat_s   = pat_in[{win_s, 2'b00} +: 4];
          last_s  = win_s;
          owner_s = win_s;
          cnt_s   = CNT_ZERO;
          busy_s  = 1'b1;
          state_s = ST_SHOW;
        end else begin
          grant_s = 4'b0000;
          led_s   = 4'b0000;
          busy_s  = 1'b0;
        end
      end
      ST_SHOW: begin
        // A completed dwell takes precedence over a simultaneous release.
        if (cnt_r == DWELL_LAST) begin
          grant_s = 4'b0000;
          led_s   = 4'b0000;
          done_s  = 4'b0001 << owner_r;
          cnt_s   = CNT_ZERO;
          state_s = ST_GAP;
        end else if (!req[owner_r]) begin
          grant_s = 4'b0000;
          led_s   = 4'b0000;
          cnt_s   = CNT_ZERO;
          state_s = ST_GAP;
        end else begin
          led_s   = pat_r;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_s   = CNT_ZERO;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        grant_s = 4'b0000;
        led_s   = 4'b0000;
        busy_s  = 1'b0;
        cnt_s   = CNT_ZERO;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, pointer and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      last_r  <= 2'd3;
      owner_r <= 2'd0;
      pat_r   <= 4'b0000;
      grant   <= 4'b0000;
      led_out <= 4'b0000;
      done    <= 4'b0000;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
      owner_r <= owner_s;
      pat_r   <= pat_s;
      grant   <= grant_s;
      led_out <= led_s;
      done    <= done_s;
      busy    <= busy_s;
    end
  end

endmodule
